mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, byte-address width (512 KB memory).
REQ-002 Parameter LINE_BYTES, default 16, bytes per line; LINE_W = 8*LINE_BYTES.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before an error completion.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester request strobe; index 0 and index 1.
REQ-007 req_write  in  2  per-requester op select: 1 = write line, 0 = read line.
REQ-008 req_addr  in  2 x ADDR_W  per-requester line address.
REQ-009 req_wdata  in  2 x LINE_W  per-requester write line.
REQ-010 req_ready  out  2  one-hot pulse; request accepted this cycle.
REQ-011 resp_valid  out  2  one-hot pulse; completion for that requester.
REQ-012 resp_err  out  1  qualifies resp_valid; 1 = timed out.
REQ-013 resp_rdata  out  LINE_W  read line, valid with resp_valid for reads.
REQ-014 mem_cmd  out  2  bus command: 0 NOP, 2 READ, 3 WRITE.
REQ-015 mem_addr, mem_wdata  out  ADDR_W, LINE_W  bus address and write line.
REQ-016 mem_resp  in  2  memory status; 1 = RESPONSE (done), otherwise ignored.
REQ-017 mem_rdata  in  LINE_W  memory read line, sampled when mem_resp == 1.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; exactly one requester is owned from accept to resp_valid.
REQ-019 IDLE: if any req_valid, grant one, pulse its req_ready, latch write/addr/wdata, go ISSUE; else stay.
REQ-020 Arbitration round-robin: on both valid, grant the index not granted last; last_grant resets to 1 so requester 0 wins first.
REQ-021 ISSUE: drive mem_cmd = 2 or 3 with latched addr/wdata for exactly one cycle, clear counter, go WAIT.
REQ-022 WAIT: mem_cmd = 0, mem_addr/mem_wdata hold; on mem_resp == 1 capture mem_rdata, go RESP.
REQ-023 WAIT: counter increments each cycle without response; reaching TIMEOUT sets error, go RESP.
REQ-024 RESP: one-cycle resp_valid to owner, resp_err = error flag, resp_rdata = captured line (zero on error or write); go IDLE.
REQ-025 Latency without contention: accept cycle N, command cycle N+1, response at N+2 at the earliest, resp_valid one cycle after mem_resp.
REQ-026 mem_resp == 1 outside WAIT is ignored; a req_valid outside IDLE is not acknowledged and must be held by the requester.
REQ-027 mem_resp == 1 in the same cycle the counter reaches TIMEOUT: the response wins, resp_err = 0.
REQ-028 Requester deasserting req_valid after accept does not affect the transaction in flight.
REQ-029 Timeout counter width = clog2(TIMEOUT+1), saturating; never wraps.

Reset
REQ-030 rst_n low: state IDLE, req_ready = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_cmd = 0, mem_addr = 0, mem_wdata = 0, counter = 0, last_grant = 1.
REQ-031 Reset mid-transaction abandons it with no resp_valid; the first post-reset grant follows REQ-020.

Structure
REQ-032 Package mem_bus_pkg holds command encodings (CMD_NOP=0, CMD_RESP=1, CMD_READ=2, CMD_WRITE=3), default ADDR_W and LINE_BYTES, and the FSM state typedef.
REQ-033 Sub-module rr_arbiter2 (2-way round-robin grant with last_grant register) is instantiated once; the rest is flat.

Verification
REQ-034 Req0 read addr 0x00040, mem_resp=1 two cycles after READ with rdata 0xA5 repeated -> mem_cmd=2 for one cycle, resp_valid[0] with rdata 0xA5.., resp_err=0.
REQ-035 Both valid in the same cycle after reset, then held -> grants 0, then 1, then 0; mem_cmd never nonzero for two consecutive cycles.
REQ-036 Req1 write addr 0x7FFF0, memory never responds, TIMEOUT=8 -> resp_valid[1], resp_err=1, 9 cycles after ISSUE.
REQ-037 mem_resp=1 on the exact cycle the counter reaches TIMEOUT -> resp_err=0, rdata captured.
REQ-038 rst_n pulsed low during WAIT -> all outputs 0 immediately, no resp_valid, next request accepted normally.
REQ-039 Spurious mem_resp=1 in IDLE and ISSUE -> no state change, no resp_valid.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - memory bus command encodings, default geometry and arbiter FSM states
package mem_bus_pkg;

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_LINE_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-grant memory
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant,
    output logic       o_grant_idx
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    // On contention hand the grant to the requester that was not served last
    always_comb begin
        w_grant = i_req;
        if (i_req == 2'b11) begin
            w_grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    assign o_grant     = i_en ? w_grant : 2'b00;
    assign o_grant_idx = w_grant[1];

    // Remember the winner of every grant actually taken; index 1 after reset so 0 wins first
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_en && (i_req != 2'b00)) begin
            r_last_grant <= w_grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester line arbiter for a single-outstanding memory bus with timeout
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LINE_BYTES  = DEF_LINE_BYTES,
    parameter int TIMEOUT     = 255,
    localparam int LINE_W     = 8 * LINE_BYTES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][LINE_W-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             resp_valid,
    output logic                   resp_err,
    output logic [LINE_W-1:0]      resp_rdata,
    output logic [1:0]             mem_cmd,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [1:0]             mem_resp,
    input  logic [LINE_W-1:0]      mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_owner;
    logic              r_write;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        w_grant;
    logic              w_grant_idx;
    logic              w_in_idle;
    logic              w_accept;
    logic              w_resp_hit;
    logic              w_timeout;

    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_accept   = |w_grant;
    assign w_resp_hit = (r_state == ST_WAIT) && (mem_resp == CMD_RESP);
    // The response takes priority over a timeout landing in the same cycle
    assign w_timeout  = (r_state == ST_WAIT) && !w_resp_hit && (r_cnt == CNT_W'(TIMEOUT - 1));

    rr_arbiter2 u_arb (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req_valid),
        .i_en        (w_in_idle),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept, one command cycle, wait for response or timeout, one response cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  if (w_resp_hit || w_timeout) w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready is held low while reset is asserted
    always_comb begin
        req_ready  = w_grant & {2{rst_n}};
        mem_cmd    = CMD_NOP;
        resp_valid = 2'b00;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (r_state)
            ST_ISSUE: mem_cmd = r_write ? CMD_WRITE : CMD_READ;
            ST_RESP: begin
                resp_valid = r_owner ? 2'b10 : 2'b01;
                resp_err   = r_err;
                resp_rdata = r_rdata;
            end
            default: ;
        endcase
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // Transaction registers: latch on accept, run the saturating timeout counter, capture read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant_idx;
                r_write <= req_write[w_grant_idx];
                r_addr  <= req_addr[w_grant_idx];
                r_wdata <= req_wdata[w_grant_idx];
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end
            if (w_resp_hit) begin
                r_rdata <= r_write ? '0 : mem_rdata;
            end else if (r_state == ST_WAIT) begin
                if (r_cnt != CNT_W'(TIMEOUT)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    localparam int ADDR_W     = 19;
    localparam int LINE_BYTES = 16;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int T          = 8;

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
    } item_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [1:0]             req_valid;
    logic [1:0]             req_write;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][LINE_W-1:0] req_wdata;
    logic [1:0]             req_ready;
    logic [1:0]             resp_valid;
    logic                   resp_err;
    logic [LINE_W-1:0]      resp_rdata;
    logic [1:0]             mem_cmd;
    logic [ADDR_W-1:0]      mem_addr;
    logic [LINE_W-1:0]      mem_wdata;
    logic [1:0]             mem_resp;
    logic [LINE_W-1:0]      mem_rdata;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .LINE_BYTES (LINE_BYTES),
        .TIMEOUT    (T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Transaction-level model: one job in flight, with the cycles at which its command and response are due
    int                free_at  = 1;
    logic              m_last   = 1'b1;
    logic              busy     = 1'b0;
    int                cmd_cyc  = 0;
    int                rsp_cyc  = 0;
    int                d_sel    = 0;
    logic              m_owner  = 1'b0;
    logic              m_write  = 1'b0;
    logic              m_err    = 1'b0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [LINE_W-1:0] m_wdata  = '0;
    logic [LINE_W-1:0] m_rdata  = '0;
    logic [1:0]        accepted = 2'b00;
    int                gen_pct  = 0;

    item_t             q0[$];
    item_t             q1[$];
    int                d_q[$];
    logic [LINE_W-1:0] rd_q[$];

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        v = '0;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, LINE_W'(req_ready), '0);
        check_eq({tag, "_rvalid"}, LINE_W'(resp_valid), '0);
        check_eq({tag, "_rerr"}, LINE_W'(resp_err), '0);
        check_eq({tag, "_rdata"}, resp_rdata, '0);
        check_eq({tag, "_cmd"}, LINE_W'(mem_cmd), '0);
        check_eq({tag, "_addr"}, LINE_W'(mem_addr), '0);
        check_eq({tag, "_wdata"}, mem_wdata, '0);
    endtask

    // One clock cycle: drive requesters and memory at negedge, then compare against the model
    task automatic step();
        logic [1:0]        exp_ready;
        logic [1:0]        exp_cmd;
        logic [1:0]        exp_rv;
        logic              in_wait;
        logic              hit;
        logic              idx;
        int                v;
        item_t             it;
        logic              have;
        @(negedge clk);
        cyc++;
        req_valid = req_valid & ~accepted;
        accepted  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (!req_valid[i]) begin
                have = 1'b0;
                if (i == 0 && q0.size() > 0) begin
                    it = q0.pop_front(); have = 1'b1;
                end else if (i == 1 && q1.size() > 0) begin
                    it = q1.pop_front(); have = 1'b1;
                end else if (int'($urandom_range(99)) < gen_pct) begin
                    it.w = 1'($urandom_range(1));
                    it.a = ADDR_W'($urandom);
                    it.d = rand_line();
                    have = 1'b1;
                end
                if (have) begin
                    req_valid[i] = 1'b1;
                    req_write[i] = it.w;
                    req_addr[i]  = it.a;
                    req_wdata[i] = it.d;
                end
            end
        end
        in_wait = busy && (cyc > cmd_cyc) && (cyc < rsp_cyc);
        hit     = in_wait && (cyc == cmd_cyc + d_sel);
        if (hit) begin
            mem_resp = CMD_RESP;
        end else if (!in_wait && $urandom_range(3) == 0) begin
            mem_resp = CMD_RESP;
        end else begin
            v = int'($urandom_range(2));
            mem_resp = (v == 0) ? 2'd0 : 2'(v + 1);
        end
        mem_rdata = hit ? m_rdata : rand_line();
        #1;
        exp_ready = 2'b00;
        if (cyc >= free_at) begin
            if (req_valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
            else                    exp_ready = req_valid;
        end
        check_eq("req_ready", LINE_W'(req_ready), LINE_W'(exp_ready));
        exp_cmd = (busy && cyc == cmd_cyc) ? (m_write ? CMD_WRITE : CMD_READ) : CMD_NOP;
        check_eq("mem_cmd", LINE_W'(mem_cmd), LINE_W'(exp_cmd));
        if (busy && cyc >= cmd_cyc && cyc <= rsp_cyc) begin
            check_eq("mem_addr", LINE_W'(mem_addr), LINE_W'(m_addr));
            check_eq("mem_wdata", mem_wdata, m_wdata);
        end
        exp_rv = (busy && cyc == rsp_cyc) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        check_eq("resp_valid", LINE_W'(resp_valid), LINE_W'(exp_rv));
        if (exp_rv != 2'b00) begin
            check_eq("resp_err", LINE_W'(resp_err), LINE_W'(m_err));
            check_eq("resp_rdata", resp_rdata, (m_write || m_err) ? '0 : m_rdata);
            busy = 1'b0;
        end
        accepted = req_ready;
        if (exp_ready != 2'b00) begin
            idx     = exp_ready[1];
            busy    = 1'b1;
            m_owner = idx;
            m_write = req_write[idx];
            m_addr  = req_addr[idx];
            m_wdata = req_wdata[idx];
            cmd_cyc = cyc + 1;
            d_sel   = (d_q.size() > 0) ? d_q.pop_front() : int'($urandom_range(1, T + 2));
            m_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : rand_line();
            if (d_sel <= T) begin
                m_err   = 1'b0;
                rsp_cyc = cmd_cyc + d_sel + 1;
            end else begin
                m_err   = 1'b1;
                rsp_cyc = cmd_cyc + T + 1;
            end
            free_at = rsp_cyc + 1;
            m_last  = idx;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset pulse taken between clock edges; any job in flight is dropped
    task automatic do_reset();
        logic [1:0] held;
        held      = req_valid;
        req_valid = 2'b00;
        rst_n     = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        rst_n     = 1'b1;
        req_valid = held;
        busy      = 1'b0;
        m_last    = 1'b1;
        free_at   = cyc + 1;
        accepted  = 2'b00;
    endtask

    initial begin
        item_t it;
        req_valid = 2'b11;
        req_write = 2'b01;
        req_addr  = '{19'h12345, 19'h00abc};
        req_wdata = '{rand_line(), rand_line()};
        mem_resp  = CMD_RESP;
        mem_rdata = rand_line();
        @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        check_all_zero("reset2");
        req_valid = 2'b00;
        mem_resp  = CMD_NOP;
        rst_n     = 1'b1;

        // Both requesters valid together and held: expect grants 0, 1, 0
        gen_pct = 0;
        it.w = 1'b0; it.a = 19'h00100; it.d = rand_line(); q0.push_back(it);
        it.w = 1'b1; it.a = 19'h00200; it.d = rand_line(); q0.push_back(it);
        it.w = 1'b0; it.a = 19'h00300; it.d = rand_line(); q1.push_back(it);
        d_q.push_back(1); d_q.push_back(2); d_q.push_back(3);
        run(30);

        // Read of 0x00040 answered two cycles after the command with 0xA5 bytes
        it.w = 1'b0; it.a = 19'h00040; it.d = rand_line(); q0.push_back(it);
        d_q.push_back(2);
        rd_q.push_back({LINE_BYTES{8'hA5}});
        run(12);

        // Write of 0x7FFF0 from requester 1 that the memory never answers
        it.w = 1'b1; it.a = 19'h7FFF0; it.d = rand_line(); q1.push_back(it);
        d_q.push_back(100);
        run(14);

        // Response arriving on the same cycle the counter reaches the limit
        it.w = 1'b0; it.a = 19'h2AAA0; it.d = rand_line(); q0.push_back(it);
        d_q.push_back(T);
        rd_q.push_back({LINE_BYTES{8'h3C}});
        run(14);

        // Reset during WAIT, then both requesters: requester 0 must win again
        it.w = 1'b0; it.a = 19'h01230; it.d = rand_line(); q0.push_back(it);
        d_q.push_back(100);
        run(4);
        do_reset();
        it.w = 1'b0; it.a = 19'h04560; it.d = rand_line(); q0.push_back(it);
        it.w = 1'b1; it.a = 19'h07890; it.d = rand_line(); q1.push_back(it);
        d_q.push_back(1); d_q.push_back(4);
        run(20);

        // Random traffic with random memory latencies, timeouts and spurious responses
        gen_pct = 40;
        run(3000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
